// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction fetch bus: memory, decode and redirect signals
interface fetch_unit_if;
    logic [31:0] instructionAddress;
    logic [31:0] instruction;
    logic        stall;
    logic        redirectValid;
    logic [31:0] redirectTarget;
    logic        ifIdValid;
    logic [31:0] ifIdInstruction;
    logic [31:0] ifIdPC;
    logic        halted;

    // The fetch unit drives addresses and the IF/ID slot.
    modport master (
        output instructionAddress,
        input  instruction,
        input  stall,
        input  redirectValid,
        input  redirectTarget,
        output ifIdValid,
        output ifIdInstruction,
        output ifIdPC,
        output halted
    );

    // The memory/decode/execute side.
    modport slave (
        input  instructionAddress,
        output instruction,
        output stall,
        output redirectValid,
        output redirectTarget,
        input  ifIdValid,
        input  ifIdInstruction,
        input  ifIdPC,
        input  halted
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-slot instruction fetch stage with BOOT/RUN/HALT control; optional FETCH_PERF_CNT_EN counters
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         reset,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]  fetchCount,
    output logic [31:0]  stallCount,
`endif
    fetch_unit_if.master bus
);

    localparam logic [31:0] ECALL_INST = 32'h0000_0073;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_pc;
    logic        r_if_id_valid;
    logic [31:0] r_if_id_instruction;
    logic [31:0] r_if_id_pc;

    logic [31:0] w_pc_next;
    logic        w_if_id_valid_next;
    logic [31:0] w_if_id_instruction_next;
    logic [31:0] w_if_id_pc_next;

    // A real capture happens only in RUN when nothing upstream blocks it.
    logic        w_run_issue;
    logic        w_is_ecall;

    assign w_run_issue = (r_state == ST_RUN) && !bus.stall && !bus.redirectValid;
    assign w_is_ecall  = (bus.instruction == ECALL_INST);

    // State register; reset always re-enters BOOT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and next datapath values; redirect beats stall, stall freezes everything.
    always_comb begin
        w_next_state             = r_state;
        w_pc_next                = r_pc;
        w_if_id_valid_next       = r_if_id_valid;
        w_if_id_instruction_next = r_if_id_instruction;
        w_if_id_pc_next          = r_if_id_pc;

        if (bus.redirectValid) begin
            // Flush the slot but keep ifIdPC; the bubble is marked by valid=0.
            w_pc_next                = bus.redirectTarget;
            w_if_id_valid_next       = 1'b0;
            w_if_id_instruction_next = NOP_INST;
            w_next_state             = ST_RUN;
        end else if (!bus.stall) begin
            unique case (r_state)
                ST_BOOT: begin
                    w_next_state = ST_RUN;
                end
                ST_RUN: begin
                    w_if_id_valid_next       = 1'b1;
                    w_if_id_instruction_next = bus.instruction;
                    w_if_id_pc_next          = r_pc;
                    if (w_is_ecall) begin
                        // PC parks on the ECALL so a later redirect is the only way out.
                        w_next_state = ST_HALT;
                    end else begin
                        w_pc_next = r_pc + 32'd1;
                    end
                end
                ST_HALT: begin
                    w_if_id_valid_next       = 1'b0;
                    w_if_id_instruction_next = NOP_INST;
                end
                default: begin
                    w_next_state = ST_BOOT;
                end
            endcase
        end
    end

    // PC and IF/ID slot registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc                <= RESET_PC;
            r_if_id_valid       <= 1'b0;
            r_if_id_instruction <= NOP_INST;
            r_if_id_pc          <= 32'd0;
        end else begin
            r_pc                <= w_pc_next;
            r_if_id_valid       <= w_if_id_valid_next;
            r_if_id_instruction <= w_if_id_instruction_next;
            r_if_id_pc          <= w_if_id_pc_next;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic        w_stall_cycle;
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    assign w_stall_cycle = (r_state == ST_RUN) && bus.stall && !bus.redirectValid;

    // Free-running event counters; both wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count <= 32'd0;
            r_stall_count <= 32'd0;
        end else begin
            if (w_run_issue) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (w_stall_cycle) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign fetchCount = r_fetch_count;
    assign stallCount = r_stall_count;
`else
    // Counters are not built in this configuration.
`endif

    assign bus.instructionAddress = r_pc;
    assign bus.ifIdValid          = r_if_id_valid;
    assign bus.ifIdInstruction    = r_if_id_instruction;
    assign bus.ifIdPC             = r_if_id_pc;
    assign bus.halted             = (r_state == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit, default and wrap-around reset PC
module tb_fetch_unit;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic tag_mem;
    logic ecall_en;

    fetch_unit_if bus0 ();
    fetch_unit_if bus1 ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count0, stall_count0, fetch_count1, stall_count1;
`endif

    fetch_unit dut0 (
        .clk   (clk),
        .reset (reset),
`ifdef FETCH_PERF_CNT_EN
        .fetchCount (fetch_count0),
        .stallCount (stall_count0),
`endif
        .bus   (bus0.master)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) dut1 (
        .clk   (clk),
        .reset (reset),
`ifdef FETCH_PERF_CNT_EN
        .fetchCount (fetch_count1),
        .stallCount (stall_count1),
`endif
        .bus   (bus1.master)
    );

    // Memory model: ECALL at word 7 when enabled, otherwise optionally address-tagged NOPs.
    assign bus0.instruction = (ecall_en && bus0.instructionAddress == 32'd7) ? 32'h0000_0073 :
                              tag_mem ? ((bus0.instructionAddress << 7) | 32'h13) : 32'h0000_0013;
    assign bus1.instruction = 32'h0000_0013;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0; errors = 0;
        tag_mem = 1'b0; ecall_en = 1'b0;
        reset = 1'b1;
        bus0.stall = 1'b1; bus0.redirectValid = 1'b1; bus0.redirectTarget = 32'h55;
        bus1.stall = 1'b0; bus1.redirectValid = 1'b0; bus1.redirectTarget = 32'h0;

        // Reset overrides stall and redirect
        step();
        check("rst_addr",  bus0.instructionAddress, 32'h0);
        check("rst_valid", {31'd0, bus0.ifIdValid}, 32'd0);
        check("rst_inst",  bus0.ifIdInstruction, 32'h13);
        check("rst_pc",    bus0.ifIdPC, 32'h0);
        check("rst_halt",  {31'd0, bus0.halted}, 32'd0);
        check("rst_addr1", bus1.instructionAddress, 32'hFFFF_FFFF);
`ifdef FETCH_PERF_CNT_EN
        check("rst_fcnt", fetch_count0, 32'd0);
        check("rst_scnt", stall_count0, 32'd0);
`endif
        reset = 1'b0; bus0.stall = 1'b0; bus0.redirectValid = 1'b0;

        // BOOT cycle: nothing captured, PC unchanged
        step();
        check("boot_valid",  {31'd0, bus0.ifIdValid}, 32'd0);
        check("boot_addr",   bus0.instructionAddress, 32'h0);
        check("boot_valid1", {31'd0, bus1.ifIdValid}, 32'd0);

        // Sequential fetch 0..4
        step();
        check("seq_valid", {31'd0, bus0.ifIdValid}, 32'd1);
        check("seq_pc0",   bus0.ifIdPC, 32'd0);
        check("seq_inst0", bus0.ifIdInstruction, 32'h13);
        check("wrap_pc1",  bus1.ifIdPC, 32'hFFFF_FFFF);
        step();
        check("seq_pc1",   bus0.ifIdPC, 32'd1);
        check("wrap_pc2",  bus1.ifIdPC, 32'd0);
        check("wrap_addr", bus1.instructionAddress, 32'd1);
        step();
        check("seq_pc2",   bus0.ifIdPC, 32'd2);
        step();
        check("seq_pc3",   bus0.ifIdPC, 32'd3);
        step();
        check("seq_pc4",   bus0.ifIdPC, 32'd4);
        check("seq_addr5", bus0.instructionAddress, 32'd5);

        // Stall three cycles at PC=5
        bus0.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr",  bus0.instructionAddress, 32'd5);
            check("stall_pc",    bus0.ifIdPC, 32'd4);
            check("stall_valid", {31'd0, bus0.ifIdValid}, 32'd1);
            check("stall_inst",  bus0.ifIdInstruction, 32'h13);
        end
        tag_mem = 1'b1;
        bus0.stall = 1'b0;
        step();
        check("rel_pc",   bus0.ifIdPC, 32'd5);
        check("rel_inst", bus0.ifIdInstruction, 32'h293);
        check("rel_addr", bus0.instructionAddress, 32'd6);
`ifdef FETCH_PERF_CNT_EN
        check("scnt3", stall_count0, 32'd3);
        check("fcnt6", fetch_count0, 32'd6);
`endif

        // ECALL at address 7
        ecall_en = 1'b1;
        step();
        check("pre_ecall_pc", bus0.ifIdPC, 32'd6);
        step();
        check("ecall_pc",    bus0.ifIdPC, 32'd7);
        check("ecall_inst",  bus0.ifIdInstruction, 32'h73);
        check("ecall_valid", {31'd0, bus0.ifIdValid}, 32'd1);
        check("ecall_halt",  {31'd0, bus0.halted}, 32'd1);
        step();
        check("halt_valid", {31'd0, bus0.ifIdValid}, 32'd0);
        check("halt_inst",  bus0.ifIdInstruction, 32'h13);
        check("halt_addr",  bus0.instructionAddress, 32'd7);
        check("halt_flag",  {31'd0, bus0.halted}, 32'd1);

        // Redirect out of HALT to 0
        bus0.redirectValid = 1'b1; bus0.redirectTarget = 32'd0;
        step();
        check("rdh_addr",  bus0.instructionAddress, 32'd0);
        check("rdh_halt",  {31'd0, bus0.halted}, 32'd0);
        check("rdh_valid", {31'd0, bus0.ifIdValid}, 32'd0);
        check("rdh_pc",    bus0.ifIdPC, 32'd7);
        bus0.redirectValid = 1'b0;
        step();
        check("res_pc",    bus0.ifIdPC, 32'd0);
        check("res_valid", {31'd0, bus0.ifIdValid}, 32'd1);

        // Redirect to 10, then redirect under stall to 0x40
        bus0.redirectValid = 1'b1; bus0.redirectTarget = 32'd10;
        step();
        check("rd10_addr", bus0.instructionAddress, 32'd10);
        bus0.stall = 1'b1; bus0.redirectTarget = 32'h40;
        step();
        check("rd40_addr",  bus0.instructionAddress, 32'h40);
        check("rd40_valid", {31'd0, bus0.ifIdValid}, 32'd0);
        check("rd40_inst",  bus0.ifIdInstruction, 32'h13);
        bus0.stall = 1'b0; bus0.redirectValid = 1'b0;
        step();
        check("tgt_pc",    bus0.ifIdPC, 32'h40);
        check("tgt_valid", {31'd0, bus0.ifIdValid}, 32'd1);
        check("tgt_inst",  bus0.ifIdInstruction, 32'h2013);

        // Halt again, then reset while stalled in HALT
        bus0.redirectValid = 1'b1; bus0.redirectTarget = 32'd7;
        step();
        bus0.redirectValid = 1'b0;
        step();
        check("halt2_flag", {31'd0, bus0.halted}, 32'd1);
        bus0.stall = 1'b1; reset = 1'b1;
        step();
        check("hrst_addr",  bus0.instructionAddress, 32'd0);
        check("hrst_valid", {31'd0, bus0.ifIdValid}, 32'd0);
        check("hrst_halt",  {31'd0, bus0.halted}, 32'd0);
        check("hrst_pc",    bus0.ifIdPC, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("hrst_fcnt", fetch_count0, 32'd0);
`endif
        reset = 1'b0;
        step();
        check("hrst_boot_hold", bus0.instructionAddress, 32'd0);
        bus0.stall = 1'b0;
        step();
        check("hrst_boot_valid", {31'd0, bus0.ifIdValid}, 32'd0);
        step();
        check("hrst_first_pc",    bus0.ifIdPC, 32'd0);
        check("hrst_first_valid", {31'd0, bus0.ifIdValid}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, word address loaded into PC on reset.
REQ-002 Parameter: NOP_INST, 32'h0000_0013, instruction word driven on ifIdInstruction when the slot is empty.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: instructionAddress  output  32  word address to instruction memory; equals PC register combinationally.
REQ-006 Port: instruction  input  32  instruction memory data for instructionAddress, valid in same cycle (combinational read).
REQ-007 Port: stall  input  1  decode cannot accept; hold PC and IF/ID outputs.
REQ-008 Port: redirectValid  input  1  branch/jump taken from execute; flush and reload PC.
REQ-009 Port: redirectTarget  input  32  word address loaded into PC when redirectValid=1.
REQ-010 Port: ifIdValid  output  1  IF/ID slot holds a real instruction.
REQ-011 Port: ifIdInstruction  output  32  registered instruction to decode.
REQ-012 Port: ifIdPC  output  32  registered word address of ifIdInstruction.
REQ-013 Port: halted  output  1  high while in HALT state.

Function
REQ-014 States BOOT, RUN, HALT; encoding free; BOOT entered only by reset.
REQ-015 BOOT: one cycle, no capture, ifIdValid stays 0, PC unchanged; next state RUN (redirect takes precedence per REQ-020).
REQ-016 RUN, stall=0, redirectValid=0: ifIdValid<=1, ifIdInstruction<=instruction, ifIdPC<=PC, PC<=PC+1 (mod 2^32; 32'hFFFF_FFFF wraps to 0).
REQ-017 RUN capture of instruction==32'h0000_0073 (ECALL): captured per REQ-016 but PC not incremented; next state HALT.
REQ-018 stall=1, redirectValid=0, any state: PC, ifIdValid, ifIdInstruction, ifIdPC, state all hold.
REQ-019 HALT, stall=0, redirectValid=0: ifIdValid<=0, ifIdInstruction<=NOP_INST, PC holds; state stays HALT.
REQ-020 redirectValid=1, any state, regardless of stall: PC<=redirectTarget, ifIdValid<=0, ifIdInstruction<=NOP_INST, ifIdPC holds, next state RUN.
REQ-021 Fetch latency: instruction at address A appears on IF/ID outputs the cycle after instructionAddress==A with stall=0.
REQ-022 Redirect penalty: exactly one bubble (ifIdValid=0) before target instruction is valid.
REQ-023 halted = (state==HALT), registered-state decode, no input dependency.

Reset
REQ-024 reset=1 at rising edge: PC<=RESET_PC, state<=BOOT, ifIdValid<=0, ifIdInstruction<=NOP_INST, ifIdPC<=0, halted=0; overrides stall and redirect.
REQ-025 reset asserted mid-stall or in HALT behaves identically to REQ-024; perf counters (if present) cleared to 0.

Configuration
REQ-026 Macro FETCH_PERF_CNT_EN defined: adds outputs fetchCount[31:0] (+1 per REQ-016/017 capture) and stallCount[31:0] (+1 per RUN cycle with stall=1 and redirectValid=0); both wrap mod 2^32.
REQ-027 FETCH_PERF_CNT_EN undefined: neither port nor counter logic exists; all other behaviour identical.

Verification
REQ-028 Reset, then memory returns 32'h0000_0013 for all addresses -> cycle after BOOT ifIdPC=0, then 1, 2, 3 on consecutive cycles, ifIdValid=1.
REQ-029 RUN with PC=5, stall=1 for 3 cycles -> ifIdPC, ifIdInstruction, instructionAddress=5 frozen; release -> PC=6 next cycle; stallCount=3 if enabled.
REQ-030 PC=10, redirectValid=1 target 32'h40 with stall=1 -> next cycle instructionAddress=32'h40, ifIdValid=0; following cycle ifIdPC=32'h40, ifIdValid=1.
REQ-031 ECALL at address 7 -> ifIdPC=7 valid one cycle, then halted=1, ifIdValid=0, instructionAddress=7 held; redirect to 0 -> halted=0, fetch resumes at 0.
REQ-032 RESET_PC=32'hFFFF_FFFF, run 2 captures -> ifIdPC=32'hFFFF_FFFF then 0.
REQ-033 reset asserted during HALT with stall=1 -> next cycle state BOOT, PC=RESET_PC, ifIdValid=0, halted=0.
